// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sticky round-robin share of one word-addressed memory port between pixel/weight readers and an output writer.
// Define MEM_ARB_STALL_CNT_EN to add saturating per-requester stall counters.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    pix_req,
  input  logic [ADDR_WIDTH-1:0]   pix_addr,
  output logic                    pix_gnt,
  output logic                    pix_rvalid,
  output logic [DATA_WIDTH-1:0]   pix_rdata,
  input  logic                    wgt_req,
  input  logic [ADDR_WIDTH-1:0]   wgt_addr,
  output logic                    wgt_gnt,
  output logic                    wgt_rvalid,
  output logic [DATA_WIDTH-1:0]   wgt_rdata,
  input  logic                    out_req,
  input  logic [ADDR_WIDTH-1:0]   out_addr,
  input  logic [DATA_WIDTH-1:0]   out_wdata,
  input  logic [DATA_WIDTH/8-1:0] out_wstrb,
  output logic                    out_gnt,
  output logic                    mem_rd,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
`ifdef MEM_ARB_STALL_CNT_EN
  output logic [31:0]             pix_stall_cnt,
  output logic [31:0]             wgt_stall_cnt,
  output logic [31:0]             out_stall_cnt,
`endif
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  logic                  en_q;
  logic [1:0]            ptr_q, ptr_d, last_q, last_d, p1, p2, win;
  logic [4:0]            cnt_q, cnt_d, cnt_n;
  logic [3:0]            req;
  logic                  any, wrap;
  logic [RD_LATENCY-1:0] tv_q, tid_q;

  assign req = {1'b0, out_req, wgt_req, pix_req};

  always_comb begin
    p1   = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    p2   = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
    any  = en_q && (|req);
    win  = req[ptr_q] ? ptr_q : req[p1] ? p1 : p2;
    cnt_n = (win == last_q) ? cnt_q + 5'd1 : 5'd1;
    wrap = (cnt_n == 5'(MAX_BURST));
    ptr_d  = !any ? ptr_q : wrap ? ((win == 2'd2) ? 2'd0 : win + 2'd1) : win;
    cnt_d  = !any ? cnt_q : wrap ? 5'd0 : cnt_n;
    last_d = any ? win : last_q;
  end

  always_comb begin
    pix_gnt   = any && (win == 2'd0);
    wgt_gnt   = any && (win == 2'd1);
    out_gnt   = any && (win == 2'd2);
    mem_rd    = pix_gnt || wgt_gnt;
    mem_we    = out_gnt;
    mem_addr  = pix_gnt ? pix_addr : wgt_gnt ? wgt_addr : out_gnt ? out_addr : '0;
    mem_wdata = out_gnt ? out_wdata : '0;
    mem_wstrb = out_gnt ? out_wstrb : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q   <= 1'b0;
      ptr_q  <= 2'd0;
      last_q <= 2'd0;
      cnt_q  <= 5'd0;
      tv_q   <= '0;
      tid_q  <= '0;
    end else begin
      en_q     <= 1'b1;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      tv_q[0]  <= mem_rd;
      tid_q[0] <= wgt_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
    end
  end

  // Tag at the last stage lines up with mem_rdata; data itself is not registered.
  assign pix_rvalid = tv_q[RD_LATENCY-1] && !tid_q[RD_LATENCY-1];
  assign wgt_rvalid = tv_q[RD_LATENCY-1] && tid_q[RD_LATENCY-1];
  assign pix_rdata  = en_q ? mem_rdata : '0;
  assign wgt_rdata  = en_q ? mem_rdata : '0;

`ifdef MEM_ARB_STALL_CNT_EN
  logic [31:0] pix_stall_q, wgt_stall_q, out_stall_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_stall_q <= '0;
      wgt_stall_q <= '0;
      out_stall_q <= '0;
    end else begin
      pix_stall_q <= pix_stall_q + 32'(en_q && pix_req && !pix_gnt && !(&pix_stall_q));
      wgt_stall_q <= wgt_stall_q + 32'(en_q && wgt_req && !wgt_gnt && !(&wgt_stall_q));
      out_stall_q <= out_stall_q + 32'(en_q && out_req && !out_gnt && !(&out_stall_q));
    end
  end
  assign pix_stall_cnt = pix_stall_q;
  assign wgt_stall_cnt = wgt_stall_q;
  assign out_stall_cnt = out_stall_q;
`endif
endmodule
